count_scheduler: RTL and testbench

Shares one WIDTH-bit wrap-around up/down counter between two requesters. Each requester asks for an N-step count run in a chosen direction over a REQ/ACK/DONE handshake. A round-robin arbiter grants the counter to one requester per job, and an FSM sequences the run one step per clock. It is the control layer placed above the lab counter datapath, which it owns internally.

---
 rtl/count_scheduler.sv | 102 ++++++++++
 tb/tb_count_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/count_scheduler.sv
// count_scheduler: round-robin arbiter and FSM sharing one wrap-around up/down counter between two requesters.
module count_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             DIR0,
  input  logic [WIDTH-1:0] STEPS0,
  input  logic             REQ1,
  input  logic             DIR1,
  input  logic [WIDTH-1:0] STEPS1,
  input  logic             ABORT,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] PRESET_VAL,
  output logic             ACK0,
  output logic             ACK1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [1:0]       GNT,
  output logic             BUSY,
  output logic [WIDTH-1:0] COUNT
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, rem_q, rem_d, steps;
  logic [1:0] gnt_q, gnt_d;
  logic dir_q, dir_d, last_q, last_d, win1;
  logic ack0_q, ack0_d, ack1_q, ack1_d, done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  // On a tie the requester that did not win last time takes the counter.
  assign win1 = REQ1 & (~REQ0 | ~last_q);
  assign steps = win1 ? STEPS1 : STEPS0;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d = rem_q;
    gnt_d = gnt_q;
    dir_d = dir_q;
    last_d = last_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    if (state_q == IDLE) begin
      if (PRESET) count_d = PRESET_VAL;
      if (REQ0 | REQ1) begin
        gnt_d = win1 ? 2'b10 : 2'b01;
        ack0_d = ~win1;
        ack1_d = win1;
        dir_d = win1 ? DIR1 : DIR0;
        rem_d = steps;
        last_d = win1;
        state_d = (steps == '0) ? FIN : RUN;
      end
    end else if (state_q == RUN) begin
      if (ABORT) state_d = FIN;
      else begin
        count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        rem_d = rem_q - WIDTH'(1);
        if (rem_q == WIDTH'(1)) state_d = FIN;
      end
    end else begin
      state_d = IDLE;
      gnt_d = 2'b00;
    end
    done0_d = (state_d == FIN) & gnt_d[0];
    done1_d = (state_d == FIN) & gnt_d[1];
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q <= '0;
      gnt_q <= 2'b00;
      dir_q <= 1'b0;
      last_q <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q <= rem_d;
      gnt_q <= gnt_d;
      dir_q <= dir_d;
      last_q <= last_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q <= busy_d;
    end
  end
  assign ACK0 = ack0_q;
  assign ACK1 = ack1_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign GNT = gnt_q;
  assign BUSY = busy_q;
  assign COUNT = count_q;
endmodule

// File: tb/tb_count_scheduler.sv
// tb_count_scheduler: directed scenario tests for count_scheduler with hand-computed expectations.
module tb_count_scheduler;
  logic CLK = 1'b0, RST = 1'b1;
  logic REQ0 = 0, DIR0 = 0, REQ1 = 0, DIR1 = 0, ABORT = 0, PRESET = 0;
  logic [15:0] STEPS0 = '0, STEPS1 = '0, PRESET_VAL = '0;
  logic ACK0, ACK1, DONE0, DONE1, BUSY;
  logic [1:0] GNT;
  logic [15:0] COUNT;
  int n_cmp = 0, n_bad = 0;

  count_scheduler #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .DIR0(DIR0), .STEPS0(STEPS0),
    .REQ1(REQ1), .DIR1(DIR1), .STEPS1(STEPS1), .ABORT(ABORT), .PRESET(PRESET),
    .PRESET_VAL(PRESET_VAL), .ACK0(ACK0), .ACK1(ACK1), .DONE0(DONE0), .DONE1(DONE1),
    .GNT(GNT), .BUSY(BUSY), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1;
    tick;
    tick;
    RST = 0;
    n_cmp++; if (COUNT !== 16'h0000) begin n_bad++; $display("FAIL reset_count got %h want 0000", COUNT); end
    n_cmp++; if (GNT !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b want 00", GNT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", BUSY); end
    n_cmp++; if ({ACK0, ACK1, DONE0, DONE1} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses got %b want 0000", {ACK0, ACK1, DONE0, DONE1}); end
    PRESET = 1;
    PRESET_VAL = 16'h1234;
    tick;
    PRESET = 0;
    n_cmp++; if (COUNT !== 16'h1234) begin n_bad++; $display("FAIL idle_preset got %h want 1234", COUNT); end
  endtask

  task automatic test_up_wrap;
    logic [15:0] exp_seq [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    PRESET = 1;
    PRESET_VAL = 16'hFFFE;
    tick;
    PRESET = 0;
    n_cmp++; if (COUNT !== 16'hFFFE) begin n_bad++; $display("FAIL up_preset got %h want fffe", COUNT); end
    REQ0 = 1; DIR0 = 1; STEPS0 = 16'd3;
    tick;
    REQ0 = 0; DIR0 = 0; STEPS0 = 16'd7;
    n_cmp++; if ({ACK0, ACK1, GNT, BUSY} !== 5'b10011) begin n_bad++; $display("FAIL up_accept got ack0/ack1/gnt/busy=%b want 10011", {ACK0, ACK1, GNT, BUSY}); end
    n_cmp++; if (COUNT !== 16'hFFFE) begin n_bad++; $display("FAIL up_accept_count got %h want fffe", COUNT); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (COUNT !== exp_seq[i]) begin n_bad++; $display("FAIL up_step%0d got %h want %h", i + 1, COUNT, exp_seq[i]); end
      n_cmp++; if ({ACK0, DONE0, BUSY} !== {1'b0, i == 2, 1'b1}) begin n_bad++; $display("FAIL up_flags%0d got ack0/done0/busy=%b want 0%0d1", i + 1, {ACK0, DONE0, BUSY}, i == 2); end
    end
    tick;
    n_cmp++; if ({DONE0, BUSY, GNT} !== 4'b0000) begin n_bad++; $display("FAIL up_idle got done0/busy/gnt=%b want 0000", {DONE0, BUSY, GNT}); end
    n_cmp++; if (COUNT !== 16'h0001) begin n_bad++; $display("FAIL up_hold got %h want 0001", COUNT); end
  endtask

  task automatic test_down_zero;
    PRESET = 1;
    PRESET_VAL = 16'h0000;
    REQ1 = 1; DIR1 = 0; STEPS1 = 16'd2;
    tick;
    PRESET = 0;
    REQ1 = 0;
    n_cmp++; if ({ACK1, GNT, COUNT} !== {1'b1, 2'b10, 16'h0000}) begin n_bad++; $display("FAIL down_accept got ack1/gnt/count=%b/%b/%h want 1/10/0000", ACK1, GNT, COUNT); end
    tick;
    n_cmp++; if (COUNT !== 16'hFFFF) begin n_bad++; $display("FAIL down_step1 got %h want ffff", COUNT); end
    tick;
    n_cmp++; if ({COUNT, DONE1} !== {16'hFFFE, 1'b1}) begin n_bad++; $display("FAIL down_step2 got count=%h done1=%b want fffe/1", COUNT, DONE1); end
    tick;
    n_cmp++; if ({BUSY, DONE1} !== 2'b00) begin n_bad++; $display("FAIL down_idle got busy/done1=%b want 00", {BUSY, DONE1}); end
    REQ1 = 1; STEPS1 = 16'd0;
    tick;
    REQ1 = 0;
    n_cmp++; if ({ACK1, DONE1, BUSY, GNT} !== 5'b11110) begin n_bad++; $display("FAIL zero_accept got ack1/done1/busy/gnt=%b want 11110", {ACK1, DONE1, BUSY, GNT}); end
    tick;
    n_cmp++; if ({ACK1, DONE1, BUSY, COUNT} !== {3'b000, 16'hFFFE}) begin n_bad++; $display("FAIL zero_idle got ack1/done1/busy=%b count=%h want 000/fffe", {ACK1, DONE1, BUSY}, COUNT); end
  endtask

  task automatic test_round_robin;
    REQ0 = 1; REQ1 = 1; DIR0 = 1; DIR1 = 1; STEPS0 = 16'd1; STEPS1 = 16'd1;
    for (int j = 0; j < 4; j++) begin
      tick;
      if (j == 3) begin REQ0 = 0; REQ1 = 0; end
      n_cmp++; if ({ACK0, ACK1, GNT} !== ((j % 2 == 0) ? 4'b1001 : 4'b0110)) begin n_bad++; $display("FAIL rr_grant%0d got ack0/ack1/gnt=%b want %b", j, {ACK0, ACK1, GNT}, (j % 2 == 0) ? 4'b1001 : 4'b0110); end
      tick;
      tick;
      n_cmp++; if ({ACK0, ACK1, BUSY} !== 3'b000) begin n_bad++; $display("FAIL rr_gap%0d got ack0/ack1/busy=%b want 000", j, {ACK0, ACK1, BUSY}); end
    end
    n_cmp++; if (COUNT !== 16'h0002) begin n_bad++; $display("FAIL rr_count got %h want 0002", COUNT); end
  endtask

  task automatic test_abort;
    PRESET = 1; PRESET_VAL = 16'h0000;
    tick;
    REQ0 = 1; DIR0 = 1; STEPS0 = 16'd10;
    PRESET = 0;
    tick;
    REQ0 = 0;
    n_cmp++; if (ACK0 !== 1'b1) begin n_bad++; $display("FAIL abort_accept got ack0=%b want 1", ACK0); end
    PRESET = 1; PRESET_VAL = 16'hABCD;
    repeat (4) tick;
    n_cmp++; if (COUNT !== 16'h0004) begin n_bad++; $display("FAIL abort_preset_ignored got %h want 0004", COUNT); end
    ABORT = 1; PRESET = 0;
    tick;
    ABORT = 0;
    n_cmp++; if ({COUNT, DONE0} !== {16'h0004, 1'b1}) begin n_bad++; $display("FAIL abort_fin got count=%h done0=%b want 0004/1", COUNT, DONE0); end
    tick;
    n_cmp++; if ({COUNT, DONE0, BUSY} !== {16'h0004, 2'b00}) begin n_bad++; $display("FAIL abort_idle got count=%h done0/busy=%b want 0004/00", COUNT, {DONE0, BUSY}); end
  endtask

  task automatic test_reset_mid_run;
    REQ0 = 1; DIR0 = 1; STEPS0 = 16'd100;
    tick;
    REQ0 = 0;
    repeat (20) tick;
    n_cmp++; if (COUNT !== 16'd24) begin n_bad++; $display("FAIL midrun_count got %h want 0018", COUNT); end
    RST = 1;
    tick;
    RST = 0;
    n_cmp++; if ({COUNT, BUSY, DONE0, GNT} !== {16'h0000, 4'b0000}) begin n_bad++; $display("FAIL midrun_reset got count=%h busy/done0/gnt=%b want 0000/0000", COUNT, {BUSY, DONE0, GNT}); end
    tick;
    n_cmp++; if ({COUNT, BUSY, DONE0} !== {16'h0000, 2'b00}) begin n_bad++; $display("FAIL midrun_after got count=%h busy/done0=%b want 0000/00", COUNT, {BUSY, DONE0}); end
    REQ0 = 1; REQ1 = 1; STEPS0 = 16'd0; STEPS1 = 16'd0;
    tick;
    REQ0 = 0; REQ1 = 0;
    n_cmp++; if ({ACK0, ACK1, GNT} !== 4'b1001) begin n_bad++; $display("FAIL midrun_first_grant got ack0/ack1/gnt=%b want 1001", {ACK0, ACK1, GNT}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_up_wrap;
    test_down_zero;
    test_round_robin;
    test_abort;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
